// File: rtl/bcd_display_mux_pkg.sv
// Shared definitions for the two-digit BCD display multiplexer.
//   state_t      : display scan states, cycled UNITS -> GAP_U -> TENS -> GAP_T
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : middle bar only, shown for non-BCD codes
//   SEG_0..SEG_9 : active-low {g,f,e,d,c,b,a} patterns for the decimal digits
//   AN_*         : active-low digit-enable patterns
package bcd_display_mux_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP_U = 2'd1,
    S_TENS  = 2'd2,
    S_GAP_T = 2'd3
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [1:0] AN_OFF   = 2'b11;
  localparam logic [1:0] AN_UNITS = 2'b10;
  localparam logic [1:0] AN_TENS  = 2'b01;

endpackage

// File: rtl/bcd_display_mux_seg7_decode.sv
// seg7_decode: combinational BCD to active-low seven-segment decoder.
//   digit : 4-bit BCD code; 10..15 are treated as invalid
//   seg   : active-low segments {g,f,e,d,c,b,a}; invalid codes show a dash
module seg7_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  import bcd_display_mux_pkg::*;

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// bcd_display_mux: time-multiplexes a two-digit BCD value onto a common
// seven-segment display with a blank gap between digits to avoid ghosting.
//   REFRESH_DIV  : cycles each digit is lit (2..2^20)
//   BLANK_CYCLES : cycles of all-off gap between digits (1..2^20)
//   clk          : single clock, rising edge
//   rst          : synchronous, active-high reset
//   tens, units  : BCD digits (10..15 invalid, shown as a dash)
//   load         : captures tens/units into the shadow pair when high
//   lzb_en       : leading-zero blanking of the tens digit
//   an           : active-low digit enables, an[0]=units, an[1]=tens
//   seg          : active-low segments {g,f,e,d,c,b,a}
module bcd_display_mux #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  input  logic       load,
  input  logic       lzb_en,
  output logic [1:0] an,
  output logic [6:0] seg
);
  import bcd_display_mux_pkg::*;

  // Wide enough to hold 2^20 - 1, the largest terminal count.
  localparam int CNT_W = 21;
  localparam logic [CNT_W-1:0] LIT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYCLES - 1);

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             at_end;
  logic             enter_units;

  logic [3:0] sh_t, sh_u;
  logic [3:0] d_t, d_u;
  logic [3:0] d_t_nxt, d_u_nxt;
  logic [3:0] dig;
  logic [6:0] dec_seg;
  logic       blank_tens;

  always_comb begin
    nxt    = S_GAP_U;
    at_end = 1'b0;
    case (state)
      S_UNITS: begin nxt = S_GAP_U; at_end = (cnt == LIT_LAST); end
      S_GAP_U: begin nxt = S_TENS;  at_end = (cnt == GAP_LAST); end
      S_TENS:  begin nxt = S_GAP_T; at_end = (cnt == LIT_LAST); end
      S_GAP_T: begin nxt = S_UNITS; at_end = (cnt == GAP_LAST); end
      default: begin nxt = S_GAP_T; at_end = 1'b1; end
    endcase
  end

  assign enter_units = at_end && (nxt == S_UNITS);

  // The display pair is refreshed from the shadow only on the frame
  // boundary; the outputs registered on that same edge must already see the
  // refreshed value, so the mux works on the next-cycle display pair.
  assign d_t_nxt = enter_units ? sh_t : d_t;
  assign d_u_nxt = enter_units ? sh_u : d_u;

  assign dig = (nxt == S_UNITS) ? d_u_nxt : d_t_nxt;

  seg7_decode u_dec (
    .digit (dig),
    .seg   (dec_seg)
  );

  // Only a genuine zero is blanked; an invalid tens code still shows a dash.
  assign blank_tens = lzb_en && (d_t_nxt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_GAP_T;
      cnt   <= '0;
      sh_t  <= 4'd0;
      sh_u  <= 4'd0;
      d_t   <= 4'd0;
      d_u   <= 4'd0;
      an    <= AN_OFF;
      seg   <= SEG_BLANK;
    end else begin
      if (load) begin
        sh_t <= tens;
        sh_u <= units;
      end
      d_t <= d_t_nxt;
      d_u <= d_u_nxt;
      if (at_end) begin
        state <= nxt;
        cnt   <= '0;
        case (nxt)
          S_UNITS: begin
            an  <= AN_UNITS;
            seg <= dec_seg;
          end
          S_TENS: begin
            if (blank_tens) begin
              an  <= AN_OFF;
              seg <= SEG_BLANK;
            end else begin
              an  <= AN_TENS;
              seg <= dec_seg;
            end
          end
          default: begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
          end
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Self-checking bench for bcd_display_mux with REFRESH_DIV=4, BLANK_CYCLES=2.
// Frame position q = edges since the reset edge, modulo 12:
//   q 0..1 gap before units, 2..5 units lit, 6..7 gap, 8..11 tens lit.
module tb_bcd_display_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tens, units;
  logic       load, lzb_en;
  logic [1:0] an;
  logic [6:0] seg;

  always #5 clk = ~clk;

  bcd_display_mux #(.REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .tens   (tens),
    .units  (units),
    .load   (load),
    .lzb_en (lzb_en),
    .an     (an),
    .seg    (seg)
  );

  int checks   = 0;
  int failures = 0;
  int e = 0;
  int q = 0;

  logic [6:0] cur_u_seg, pend_u_seg;
  logic [1:0] cur_t_an,  pend_t_an;
  logic [6:0] cur_t_seg, pend_t_seg;

  typedef struct {
    logic [3:0] t;
    logic [3:0] u;
    logic       lzb;
    logic [6:0] u_seg;
    logic [1:0] t_an;
    logic [6:0] t_seg;
  } vec_t;

  vec_t vecs[8];

  // Both digit enables low would light two digits with one segment pattern.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if (an === 2'b00) begin
        failures++;
        $display("FAIL an_never_00 t=%0t an=%b required not 00", $time, an);
      end
    end
  end

  task automatic check(input string name, input logic [1:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    if (an !== exp_an || seg !== exp_seg) begin
      failures++;
      $display("FAIL %s e=%0d q=%0d an=%b seg=%h required an=%b seg=%h",
               name, e, q, an, seg, exp_an, exp_seg);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    #1;
    e++;
    q = e % 12;
    if (q == 2) begin
      cur_u_seg = pend_u_seg;
      cur_t_an  = pend_t_an;
      cur_t_seg = pend_t_seg;
    end
    if (q >= 2 && q <= 5)       check(name, 2'b10, cur_u_seg);
    else if (q >= 8 && q <= 11) check(name, cur_t_an, cur_t_seg);
    else                        check(name, 2'b11, 7'h7F);
  endtask

  task automatic wait_q(input int target, input string name);
    int n;
    n = 0;
    while (q != target && n < 30) begin
      tick(name);
      n++;
    end
    if (q != target) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout q=%0d required %0d", name, q, target);
    end
  endtask

  task automatic set_expect_zero();
    cur_u_seg  = 7'h40; pend_u_seg = 7'h40;
    cur_t_an   = 2'b01; pend_t_an  = 2'b01;
    cur_t_seg  = 7'h40; pend_t_seg = 7'h40;
  endtask

  initial begin
    //          tens   units  lzb   u_seg  t_an   t_seg
    vecs[0] = '{4'd4,  4'd7,  1'b0, 7'h78, 2'b01, 7'h19};
    vecs[1] = '{4'd0,  4'd5,  1'b1, 7'h12, 2'b11, 7'h7F};
    vecs[2] = '{4'd10, 4'd5,  1'b1, 7'h12, 2'b01, 7'h3F};
    vecs[3] = '{4'd9,  4'd15, 1'b1, 7'h3F, 2'b01, 7'h10};
    vecs[4] = '{4'd2,  4'd8,  1'b0, 7'h00, 2'b01, 7'h24};
    vecs[5] = '{4'd6,  4'd3,  1'b1, 7'h30, 2'b01, 7'h02};
    vecs[6] = '{4'd1,  4'd0,  1'b1, 7'h40, 2'b01, 7'h79};
    vecs[7] = '{4'd0,  4'd5,  1'b0, 7'h12, 2'b01, 7'h40};

    rst = 1'b1; load = 1'b0; lzb_en = 1'b0; tens = 4'd0; units = 4'd0;
    set_expect_zero();

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", 2'b11, 7'h7F);
    rst = 1'b0;
    e = 0; q = 0;

    // Idle: two full frames of zeros.
    repeat (24) tick("idle");

    // Loads mid-tens; the current frame must finish unchanged.
    for (int i = 0; i < 8; i++) begin
      wait_q(9, "vec");
      tens = vecs[i].t; units = vecs[i].u; lzb_en = vecs[i].lzb; load = 1'b1;
      pend_u_seg = vecs[i].u_seg;
      pend_t_an  = vecs[i].t_an;
      pend_t_seg = vecs[i].t_seg;
      tick("vec_load");
      load = 1'b0;
    end
    wait_q(9, "vec_last");

    // lzb_en raised mid-tens: takes effect only in the following frame.
    lzb_en = 1'b1;
    pend_t_an = 2'b11; pend_t_seg = 7'h7F;
    tick("lzb_late");
    wait_q(9, "lzb_late");

    // Shadow 1/2, then a load of 3/3 exactly on the frame-boundary edge.
    lzb_en = 1'b0;
    tens = 4'd1; units = 4'd2; load = 1'b1;
    pend_u_seg = 7'h24; pend_t_an = 2'b01; pend_t_seg = 7'h79;
    tick("boundary_pre");
    load = 1'b0;
    wait_q(1, "boundary_pre");
    tens = 4'd3; units = 4'd3; load = 1'b1;
    tick("boundary_edge");
    load = 1'b0;
    pend_u_seg = 7'h30; pend_t_an = 2'b01; pend_t_seg = 7'h30;
    wait_q(1, "boundary_old");
    wait_q(11, "boundary_new");

    // Reset in the middle of units, with a load that must be ignored.
    wait_q(3, "rst_mid_pre");
    rst = 1'b1; load = 1'b1; tens = 4'd8; units = 4'd8;
    @(posedge clk); #1;
    check("rst_mid", 2'b11, 7'h7F);
    load = 1'b0;
    @(posedge clk); #1;
    check("rst_hold", 2'b11, 7'h7F);
    rst = 1'b0;
    e = 0; q = 0;
    set_expect_zero();
    repeat (24) tick("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit is lit (legal range 2..2^20).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16, giving the clock cycles of all-off gap between digits (legal range 1..2^20).
REQ-003 clk  input  1  single clock, all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tens  input  4  BCD tens digit from the binary-to-BCD stage; codes 10..15 mean invalid.
REQ-006 units  input  4  BCD units digit; codes 10..15 mean invalid.
REQ-007 load  input  1  capture strobe, sampled every clk; tens/units are captured in any cycle where load=1.
REQ-008 lzb_en  input  1  leading-zero blanking enable.
REQ-009 an  output  2  digit enables, active-low; an[0]=units, an[1]=tens.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-011 Input capture SHALL be a shadow pair (sh_t, sh_u) written on every clk with load=1; the shadow pair SHALL NOT be driven to the outputs directly.
REQ-012 A display pair (d_t, d_u) SHALL be copied from the shadow pair only at the frame boundary (the edge entering S_UNITS), so a frame never mixes old and new digits.
REQ-013 When load=1 on the frame-boundary edge, the display pair SHALL take the old shadow value and the shadow SHALL take the new inputs (no bypass).
REQ-014 The FSM SHALL have states S_UNITS -> S_GAP_U -> S_TENS -> S_GAP_T -> S_UNITS, cyclic, with no other transitions except reset.
REQ-015 S_UNITS and S_TENS SHALL each last exactly REFRESH_DIV cycles; S_GAP_U and S_GAP_T SHALL each last exactly BLANK_CYCLES cycles; the frame period SHALL be 2*REFRESH_DIV + 2*BLANK_CYCLES cycles.
REQ-016 A single dwell counter SHALL reset to 0 on each state entry and advance the state when it equals duration-1.
REQ-017 an and seg SHALL be registers taking the new state's values on the same edge that enters that state.
REQ-018 In S_UNITS: an=2'b10, seg=decode(d_u).
REQ-019 In S_TENS: an=2'b01, seg=decode(d_t).
REQ-020 Exception in S_TENS: when lzb_en=1 and d_t=0, an SHALL be 2'b11 and seg SHALL be 7'h7F.
REQ-021 In both gap states: an=2'b11, seg=7'h7F.
REQ-022 decode SHALL map 0..9 to 7'h40,79,24,30,19,12,02,78,00,10.
REQ-023 decode SHALL map codes 10..15 to a dash, 7'h3F.
REQ-024 An invalid tens code SHALL NOT be blanked by lzb_en.
REQ-025 lzb_en SHALL be sampled on the edge entering S_TENS; changes within S_TENS SHALL take effect in the next frame.
REQ-026 an SHALL never have both bits 0 in any cycle.

Reset
REQ-027 On any clk edge with rst=1: state=S_GAP_T, counter=0, sh_t=sh_u=d_t=d_u=0, an=2'b11, seg=7'h7F; load SHALL be ignored that cycle.
REQ-028 After rst deasserts, the first S_UNITS entry SHALL occur BLANK_CYCLES cycles later.
REQ-029 Reset asserted mid-state SHALL abort the frame with no further lit cycles.

Structure
REQ-030 A shared package SHALL hold the state enumeration, SEG_BLANK (7'h7F), SEG_DASH (7'h3F), and the ten digit patterns.
REQ-031 decode SHALL be a separate combinational sub-module seg7_decode (4-bit in, 7-bit out), instantiated once and fed by a state-selected digit mux.

Verification
All benches use REFRESH_DIV=4 and BLANK_CYCLES=2.
REQ-032 Reset then idle -> an=11 for 2 cycles; an=10 with seg=40 for 4 cycles; an=11 for 2 cycles; an=01 with seg=40 for 4 cycles; repeating with a 12-cycle period.
REQ-033 load with tens=4, units=7 mid-S_TENS -> the current frame is unchanged; the next frame shows seg=78 in S_UNITS and seg=19 in S_TENS.
REQ-034 lzb_en=1, load tens=0, units=5 -> S_UNITS seg=12; S_TENS an=11 and seg=7F.
REQ-035 Same with tens=10 (invalid) -> S_TENS an=01 and seg=3F despite lzb_en=1.
REQ-036 load on the exact frame-boundary edge with 3/3 after a shadow of 1/2 -> this frame shows 1/2, the next shows 3/3.
REQ-037 rst pulsed in the middle of S_UNITS -> the next edge gives an=11 and seg=7F; d_u=0; the checker confirms an never equals 00 across the whole run.
